// File: rtl/mmio_bus_controller.sv
// mmio_bus_controller
// Address decoder and MMIO register block between the core's data port,
// the data RAM, a set of GPIO channels and a UART. Holds an RX byte FIFO,
// sticky RX error flags and a TX-send handshake that stalls the core while
// the transmitter is busy.
// Optional: define MMIO_IRQ_EN to build the IRQ_EN register and the
// registered interrupt output; otherwise irq is tied low and IRQ_EN reads 0.
module mmio_bus_controller #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RAM_BASE   = 32'h1001_0000,
   parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 32'h1001_0024,
   parameter int                    GPIO_CH    = 2,
   parameter int                    RX_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          re,
   input  logic                          we,
   input  logic [ADDR_WIDTH-1:0]         A,
   input  logic [DATA_WIDTH-1:0]         WD,
   output logic [DATA_WIDTH-1:0]         RD,
   output logic                          stall,
   output logic                          bus_err,
   input  logic [DATA_WIDTH-1:0]         ReadRAM,
   output logic                          weRAM,
   output logic [ADDR_WIDTH-1:0]         AddrRAM,
   output logic [DATA_WIDTH-1:0]         DataRAM,
   output logic [GPIO_CH-1:0]            gpio_we,
   output logic [DATA_WIDTH-1:0]         gpio_wdata,
   input  logic [GPIO_CH*DATA_WIDTH-1:0] gpio_rdata,
   input  logic                          rx_valid,
   input  logic [7:0]                    rx_byte,
   input  logic                          parity_error,
   input  logic                          tx_busy,
   output logic [7:0]                    tx_data,
   output logic                          tx_start,
   output logic                          irq
);

   localparam int PTR_W = $clog2(RX_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Register offsets relative to MMIO_BASE; the UART block follows the GPIO pairs.
   localparam logic [ADDR_WIDTH-1:0] OFF_RX_DATA = ADDR_WIDTH'(8 * GPIO_CH + 0);
   localparam logic [ADDR_WIDTH-1:0] OFF_TX_DATA = ADDR_WIDTH'(8 * GPIO_CH + 4);
   localparam logic [ADDR_WIDTH-1:0] OFF_STATUS  = ADDR_WIDTH'(8 * GPIO_CH + 8);
   localparam logic [ADDR_WIDTH-1:0] OFF_TX_SEND = ADDR_WIDTH'(8 * GPIO_CH + 12);
   localparam logic [ADDR_WIDTH-1:0] OFF_IRQ_EN  = ADDR_WIDTH'(8 * GPIO_CH + 16);

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_WAIT = 2'd1,
      TX_SEND = 2'd2
   } tx_state_t;

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   logic [ADDR_WIDTH-1:0] mmio_off;
   logic                  above_mmio;
   logic                  ram_hit;
   logic [GPIO_CH-1:0]    gpio_wr_hit;
   logic [GPIO_CH-1:0]    gpio_rd_hit;
   logic                  rx_data_hit, tx_data_hit, status_hit, tx_send_hit, irq_en_hit;
   logic                  mapped;
   logic                  wr_ok;

   assign mmio_off    = A - MMIO_BASE;
   assign above_mmio  = (A >= MMIO_BASE);
   assign ram_hit     = (A >= RAM_BASE) && (A < MMIO_BASE);
   assign rx_data_hit = above_mmio && (mmio_off == OFF_RX_DATA);
   assign tx_data_hit = above_mmio && (mmio_off == OFF_TX_DATA);
   assign status_hit  = above_mmio && (mmio_off == OFF_STATUS);
   assign tx_send_hit = above_mmio && (mmio_off == OFF_TX_SEND);
   assign irq_en_hit  = above_mmio && (mmio_off == OFF_IRQ_EN);

   // Per-channel GPIO decode: write port at +8i, read port at +8i+4.
   always_comb begin
      // NOTE: every signal driven here gets a default first so no latch is inferred.
      gpio_wr_hit = '0;
      gpio_rd_hit = '0;
      for (int i = 0; i < GPIO_CH; i++) begin
         gpio_wr_hit[i] = above_mmio && (mmio_off == ADDR_WIDTH'(8 * i));
         gpio_rd_hit[i] = above_mmio && (mmio_off == ADDR_WIDTH'(8 * i + 4));
      end
   end

   assign mapped  = ram_hit | (|gpio_wr_hit) | (|gpio_rd_hit) | rx_data_hit |
                    tx_data_hit | status_hit | tx_send_hit | irq_en_hit;
   assign bus_err = (re | we) & ~mapped;

   // A write only takes effect while the core is not being held.
   assign wr_ok = we & ~stall;

   // RAM and GPIO pass-through
   assign weRAM      = ram_hit & wr_ok;
   assign AddrRAM    = A;
   assign DataRAM    = WD;
   assign gpio_we    = gpio_wr_hit & {GPIO_CH{wr_ok}};
   assign gpio_wdata = WD;

   // ------------------------------------------------------------------
   // RX FIFO
   // ------------------------------------------------------------------
   logic [7:0]       rx_mem [RX_DEPTH];
   logic [PTR_W-1:0] rx_wr_ptr, rx_rd_ptr;
   logic [CNT_W-1:0] rx_count, rx_count_next;
   logic             rx_empty, rx_full;
   logic             rx_pop, rx_push, rx_ovf_event;
   logic [7:0]       rx_head;

   assign rx_empty     = (rx_count == '0);
   assign rx_full      = (rx_count == CNT_W'(RX_DEPTH));
   assign rx_pop       = re & ~stall & rx_data_hit & ~rx_empty;
   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign rx_push      = rx_valid & (~rx_full | rx_pop);
   assign rx_ovf_event = rx_valid & rx_full & ~rx_pop;
   assign rx_head      = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];

   // Occupancy after this cycle's push/pop.
   always_comb begin
      rx_count_next = rx_count;
      case ({rx_push, rx_pop})
         2'b10:   rx_count_next = rx_count + CNT_W'(1);
         2'b01:   rx_count_next = rx_count - CNT_W'(1);
         default: rx_count_next = rx_count;
      endcase
   end

   // FIFO storage write port.
   // NOTE: the byte array carries no reset; the pointers and count define which entries are valid.
   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wr_ptr] <= rx_byte;
   end

   // FIFO pointers and occupancy; pointers wrap naturally at RX_DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else begin
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
         rx_count <= rx_count_next;
      end
   end

   // ------------------------------------------------------------------
   // Sticky error flags and TX data register
   // ------------------------------------------------------------------
   logic       rx_overflow, parity_err;
   logic       rx_overflow_next, parity_err_next;
   logic [1:0] status_clr;

   // W1C on STATUS bits 3:2; a same-cycle event wins over the clear.
   assign status_clr       = (wr_ok & status_hit) ? WD[3:2] : 2'b00;
   assign rx_overflow_next = rx_ovf_event | (rx_overflow & ~status_clr[0]);
   assign parity_err_next  = parity_error | (parity_err & ~status_clr[1]);

   // Sticky flag and TX byte registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_overflow <= 1'b0;
         parity_err  <= 1'b0;
         tx_data     <= 8'h00;
      end else begin
         rx_overflow <= rx_overflow_next;
         parity_err  <= parity_err_next;
         if (wr_ok && tx_data_hit) tx_data <= WD[7:0];
      end
   end

   // ------------------------------------------------------------------
   // Interrupt enable and interrupt request
   // ------------------------------------------------------------------
   logic irq_en;

`ifdef MMIO_IRQ_EN
   logic irq_en_next;

   assign irq_en_next = (wr_ok && irq_en_hit) ? WD[0] : irq_en;

   // irq follows the post-edge flag values so it rises/falls one cycle after its cause.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_en <= 1'b0;
         irq    <= 1'b0;
      end else begin
         irq_en <= irq_en_next;
         irq    <= irq_en_next & ((rx_count_next != '0) | rx_overflow_next | parity_err_next);
      end
   end
`else
   assign irq_en = 1'b0;
   assign irq    = 1'b0;
`endif

   // ------------------------------------------------------------------
   // TX send handshake FSM
   // ------------------------------------------------------------------
   tx_state_t tx_state, tx_state_next;
   logic      send_req;

   assign send_req = we & tx_send_hit & (WD != '0);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tx_state <= TX_IDLE;
      else        tx_state <= tx_state_next;
   end

   // Next-state logic; SEND ignores the still-present TX_SEND write.
   always_comb begin
      tx_state_next = tx_state;
      case (tx_state)
         TX_IDLE: if (send_req) tx_state_next = tx_busy ? TX_WAIT : TX_SEND;
         TX_WAIT: if (!tx_busy) tx_state_next = TX_SEND;
         TX_SEND: tx_state_next = TX_IDLE;
         default: tx_state_next = TX_IDLE;
      endcase
   end

   // Outputs; stall is forced low while reset is asserted so the core is released at once.
   always_comb begin
      stall    = 1'b0;
      tx_start = 1'b0;
      case (tx_state)
         TX_IDLE: stall    = send_req & tx_busy;
         TX_WAIT: stall    = 1'b1;
         TX_SEND: tx_start = 1'b1;
         default: stall    = 1'b0;
      endcase
      if (!rst_n) stall = 1'b0;
   end

   // ------------------------------------------------------------------
   // Read data mux
   // ------------------------------------------------------------------
   logic [7:0] status_byte;

   assign status_byte = {4'(rx_count), parity_err, rx_overflow, tx_busy, ~rx_empty};

   // Combinational read data; zero for no read, unmapped or write-only addresses.
   always_comb begin
      RD = '0;
      if (re) begin
         if (ram_hit) RD = ReadRAM;
         for (int i = 0; i < GPIO_CH; i++) begin
            if (gpio_rd_hit[i]) RD = gpio_rdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
         if (rx_data_hit) RD = DATA_WIDTH'(rx_head);
         if (status_hit)  RD = DATA_WIDTH'(status_byte);
         if (tx_send_hit) RD = DATA_WIDTH'(tx_busy);
         if (irq_en_hit)  RD = DATA_WIDTH'(irq_en);
      end
   end

endmodule

// File: tb/tb_mmio_bus_controller.sv
// Directed testbench for mmio_bus_controller with default parameters
// (GPIO_CH=2, UART base 0x10010034). IRQ checks adapt to MMIO_IRQ_EN.
module tb_mmio_bus_controller;

   localparam logic [31:0] RAM_LO  = 32'h1001_0000;
   localparam logic [31:0] GPIO0_W = 32'h1001_0024;
   localparam logic [31:0] GPIO0_R = 32'h1001_0028;
   localparam logic [31:0] GPIO1_W = 32'h1001_002C;
   localparam logic [31:0] GPIO1_R = 32'h1001_0030;
   localparam logic [31:0] RX_DATA = 32'h1001_0034;
   localparam logic [31:0] TX_DATA = 32'h1001_0038;
   localparam logic [31:0] STATUS  = 32'h1001_003C;
   localparam logic [31:0] TX_SEND = 32'h1001_0040;
   localparam logic [31:0] IRQ_EN  = 32'h1001_0044;

   logic        clk = 1'b0;
   logic        rst_n, re, we, stall, bus_err, weRAM;
   logic [31:0] A, WD, RD, ReadRAM, AddrRAM, DataRAM, gpio_wdata;
   logic [1:0]  gpio_we;
   logic [63:0] gpio_rdata;
   logic        rx_valid, parity_error, tx_busy, tx_start, irq;
   logic [7:0]  rx_byte, tx_data;

   int errors = 0;
   int checks = 0;

   mmio_bus_controller dut (
      .clk(clk), .rst_n(rst_n), .re(re), .we(we), .A(A), .WD(WD), .RD(RD),
      .stall(stall), .bus_err(bus_err), .ReadRAM(ReadRAM), .weRAM(weRAM),
      .AddrRAM(AddrRAM), .DataRAM(DataRAM), .gpio_we(gpio_we),
      .gpio_wdata(gpio_wdata), .gpio_rdata(gpio_rdata), .rx_valid(rx_valid),
      .rx_byte(rx_byte), .parity_error(parity_error), .tx_busy(tx_busy),
      .tx_data(tx_data), .tx_start(tx_start), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      re = r; we = w; A = a; WD = d;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; drive(0, 0, 32'h0, 32'h0);
      ReadRAM = 32'h0; gpio_rdata = 64'h0; rx_valid = 1'b0; rx_byte = 8'h0;
      parity_error = 1'b0; tx_busy = 1'b0;
      #1;
      checks++; if (stall !== 1'b0)    begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start: got %b want 0", tx_start); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
      checks++; if (irq !== 1'b0)      begin errors++; $display("FAIL rst_irq: got %b want 0", irq); end
      checks++; if (RD !== 32'h0)      begin errors++; $display("FAIL rst_rd: got %h want 0", RD); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); drive(1, 0, STATUS, 32'h0); #1;
      checks++; if (RD !== 32'h0) begin errors++; $display("FAIL rst_status: got %h want 0", RD); end
   endtask

   task automatic test_gpio();
      gpio_rdata = {32'h0000_005A, 32'h0000_0077};
      @(negedge clk); drive(0, 1, GPIO0_W, 32'h0000_A5A5); #1;
      checks++; if (gpio_we !== 2'b01) begin errors++; $display("FAIL gpio_we0: got %b want 01", gpio_we); end
      checks++; if (gpio_wdata !== 32'hA5A5) begin errors++; $display("FAIL gpio_wdata: got %h want a5a5", gpio_wdata); end
      checks++; if (weRAM !== 1'b0) begin errors++; $display("FAIL gpio_no_ram: got %b want 0", weRAM); end
      @(negedge clk); drive(0, 1, GPIO1_W, 32'h1); #1;
      checks++; if (gpio_we !== 2'b10) begin errors++; $display("FAIL gpio_we1: got %b want 10", gpio_we); end
      @(negedge clk); drive(1, 0, GPIO1_R, 32'h0); #1;
      checks++; if (RD !== 32'h5A) begin errors++; $display("FAIL gpio_rd1: got %h want 5a", RD); end
      @(negedge clk); drive(1, 0, GPIO0_R, 32'h0); #1;
      checks++; if (RD !== 32'h77) begin errors++; $display("FAIL gpio_rd0: got %h want 77", RD); end
      @(negedge clk); drive(0, 0, GPIO1_R, 32'h0); #1;
      checks++; if (RD !== 32'h0) begin errors++; $display("FAIL rd_no_re: got %h want 0", RD); end
   endtask

   task automatic test_rx_fifo();
      logic [7:0] pushes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      logic [7:0] round2 [4] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
      logic [7:0] drain2 [4] = '{8'hC2, 8'hC3, 8'hC4, 8'h66};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); drive(0, 0, 32'h0, 32'h0); rx_valid = 1'b1; rx_byte = pushes[i];
      end
      @(negedge clk); rx_valid = 1'b0; drive(1, 0, STATUS, 32'h0); #1;
      checks++; if (RD !== 32'h45) begin errors++; $display("FAIL rx_status_full: got %h want 45", RD); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); drive(1, 0, RX_DATA, 32'h0); #1;
         checks++; if (RD !== {24'h0, pushes[i]}) begin errors++; $display("FAIL rx_pop%0d: got %h want %h", i, RD, pushes[i]); end
      end
      @(negedge clk); drive(1, 0, RX_DATA, 32'h0); #1;
      checks++; if (RD !== 32'h0) begin errors++; $display("FAIL rx_pop_empty: got %h want 0", RD); end
      @(negedge clk); drive(1, 0, STATUS, 32'h0); #1;
      checks++; if (RD !== 32'h04) begin errors++; $display("FAIL rx_status_ovf: got %h want 04", RD); end
      @(negedge clk); drive(0, 1, STATUS, 32'h4);
      @(negedge clk); drive(1, 0, STATUS, 32'h0); #1;
      checks++; if (RD !== 32'h00) begin errors++; $display("FAIL rx_ovf_clear: got %h want 00", RD); end
      // Fill again, then push and pop together while full; pointers wrap here.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); drive(0, 0, 32'h0, 32'h0); rx_valid = 1'b1; rx_byte = round2[i];
      end
      @(negedge clk); rx_byte = 8'h66; drive(1, 0, RX_DATA, 32'h0); #1;
      checks++; if (RD !== 32'hC1) begin errors++; $display("FAIL rx_full_pushpop: got %h want c1", RD); end
      @(negedge clk); rx_valid = 1'b0; drive(1, 0, STATUS, 32'h0); #1;
      checks++; if (RD !== 32'h41) begin errors++; $display("FAIL rx_status_no_ovf: got %h want 41", RD); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); drive(1, 0, RX_DATA, 32'h0); #1;
         checks++; if (RD !== {24'h0, drain2[i]}) begin errors++; $display("FAIL rx_wrap%0d: got %h want %h", i, RD, drain2[i]); end
      end
      @(negedge clk); drive(0, 0, 32'h0, 32'h0);
   endtask

   task automatic test_tx_send();
      @(negedge clk); drive(0, 1, TX_DATA, 32'h0000_0141);
      @(negedge clk); drive(0, 1, TX_SEND, 32'h1); #1;
      checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL tx_data: got %h want 41", tx_data); end
      checks++; if (stall !== 1'b0 || tx_start !== 1'b0) begin errors++; $display("FAIL tx_req: stall=%b start=%b want 0 0", stall, tx_start); end
      @(negedge clk); drive(0, 0, 32'h0, 32'h0); #1;
      checks++; if (tx_start !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL tx_pulse: start=%b stall=%b want 1 0", tx_start, stall); end
      @(negedge clk); #1;
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL tx_pulse_end: got %b want 0", tx_start); end
      // A zero write to TX_SEND does nothing even with the transmitter busy.
      @(negedge clk); tx_busy = 1'b1; drive(0, 1, TX_SEND, 32'h0); #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL tx_zero_stall: got %b want 0", stall); end
      @(negedge clk); drive(1, 0, TX_SEND, 32'h0); #1;
      checks++; if (tx_start !== 1'b0 || RD !== 32'h1) begin errors++; $display("FAIL tx_zero_idle: start=%b RD=%h want 0 1", tx_start, RD); end
      @(negedge clk); tx_busy = 1'b0; drive(0, 0, 32'h0, 32'h0);
   endtask

   task automatic test_tx_stall();
      int stall_cnt = 0;
      int start_cnt = 0;
      int start_k   = -1;
      bit done      = 1'b0;
      @(negedge clk); tx_busy = 1'b1; drive(0, 0, 32'h0, 32'h0);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (k == 4) tx_busy = 1'b0;
         if (done) drive(0, 0, 32'h0, 32'h0);
         else if (k == 1 || k == 2) drive(0, 1, RAM_LO, 32'hBAD0_BAD0);
         else drive(0, 1, TX_SEND, 32'h1);
         #1;
         if (k == 1 || k == 2) begin
            checks++; if (weRAM !== 1'b0) begin errors++; $display("FAIL stall_ram_we%0d: got %b want 0", k, weRAM); end
         end
         if (stall === 1'b1) stall_cnt++;
         if (tx_start === 1'b1) begin
            start_cnt++;
            if (start_k < 0) start_k = k;
            done = 1'b1;
         end
      end
      checks++; if (stall_cnt != 5) begin errors++; $display("FAIL stall_cycles: got %0d want 5", stall_cnt); end
      checks++; if (start_cnt != 1) begin errors++; $display("FAIL stall_starts: got %0d want 1", start_cnt); end
      checks++; if (start_k != 5)   begin errors++; $display("FAIL stall_start_cycle: got %0d want 5", start_k); end
   endtask

   task automatic test_map();
      ReadRAM = 32'hDEAD_BEEF;
      @(negedge clk); drive(1, 0, 32'h1002_0000, 32'h0); #1;
      checks++; if (bus_err !== 1'b1 || RD !== 32'h0) begin errors++; $display("FAIL unmapped_rd: err=%b RD=%h want 1 0", bus_err, RD); end
      @(negedge clk); drive(0, 1, 32'h1001_0048, 32'h5); #1;
      checks++; if (bus_err !== 1'b1 || weRAM !== 1'b0 || gpio_we !== 2'b00) begin errors++; $display("FAIL unmapped_wr: err=%b weRAM=%b gpio_we=%b want 1 0 00", bus_err, weRAM, gpio_we); end
      @(negedge clk); drive(1, 0, 32'h1000_FFFC, 32'h0); #1;
      checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL below_ram: got %b want 1", bus_err); end
      @(negedge clk); drive(1, 0, RAM_LO, 32'h0); #1;
      checks++; if (RD !== 32'hDEAD_BEEF || bus_err !== 1'b0) begin errors++; $display("FAIL ram_rd: RD=%h err=%b want deadbeef 0", RD, bus_err); end
      @(negedge clk); drive(0, 1, 32'h1001_0020, 32'h1234_5678); #1;
      checks++; if (weRAM !== 1'b1 || AddrRAM !== 32'h1001_0020 || DataRAM !== 32'h1234_5678) begin errors++; $display("FAIL ram_wr: we=%b addr=%h data=%h", weRAM, AddrRAM, DataRAM); end
      @(negedge clk); drive(0, 0, 32'h0, 32'h0);
   endtask

   task automatic test_irq();
      @(negedge clk); drive(0, 1, IRQ_EN, 32'h1); #1;
      checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL irq_en_wr_err: got %b want 0", bus_err); end
      @(negedge clk); drive(1, 0, IRQ_EN, 32'h0); #1;
`ifdef MMIO_IRQ_EN
      checks++; if (RD !== 32'h1 || irq !== 1'b0) begin errors++; $display("FAIL irq_en_rd: RD=%h irq=%b want 1 0", RD, irq); end
`else
      checks++; if (RD !== 32'h0 || irq !== 1'b0) begin errors++; $display("FAIL irq_en_rd: RD=%h irq=%b want 0 0", RD, irq); end
`endif
      @(negedge clk); drive(0, 0, 32'h0, 32'h0); parity_error = 1'b1; #1;
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_before: got %b want 0", irq); end
      @(negedge clk); parity_error = 1'b0; drive(1, 0, STATUS, 32'h0); #1;
      checks++; if (RD !== 32'h08) begin errors++; $display("FAIL parity_sticky: got %h want 08", RD); end
`ifdef MMIO_IRQ_EN
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", irq); end
`else
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_tied: got %b want 0", irq); end
`endif
      @(negedge clk); drive(0, 1, STATUS, 32'h8);
      @(negedge clk); drive(1, 0, STATUS, 32'h0); #1;
      checks++; if (irq !== 1'b0 || RD !== 32'h0) begin errors++; $display("FAIL irq_clear: irq=%b RD=%h want 0 0", irq, RD); end
      @(negedge clk); drive(0, 0, 32'h0, 32'h0);
   endtask

   task automatic test_reset_mid_wait();
      int starts = 0;
      @(negedge clk); tx_busy = 1'b1; parity_error = 1'b1; drive(0, 1, TX_SEND, 32'h1);
      @(negedge clk); parity_error = 1'b0; #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL wait_stall: got %b want 1", stall); end
`ifdef MMIO_IRQ_EN
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL wait_irq: got %b want 1", irq); end
`endif
      #1 rst_n = 1'b0; #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstw_stall: got %b want 0", stall); end
      checks++; if (irq !== 1'b0)   begin errors++; $display("FAIL rstw_irq: got %b want 0", irq); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rstw_tx_data: got %h want 00", tx_data); end
      @(negedge clk); drive(0, 0, 32'h0, 32'h0); tx_busy = 1'b0; rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         if (tx_start === 1'b1) starts++;
      end
      checks++; if (starts != 0) begin errors++; $display("FAIL rstw_dropped: starts=%0d want 0", starts); end
      drive(1, 0, STATUS, 32'h0); #1;
      checks++; if (RD !== 32'h0) begin errors++; $display("FAIL rstw_status: got %h want 0", RD); end
   endtask

   initial begin
      test_reset();
      test_gpio();
      test_rx_fifo();
      test_tx_send();
      test_tx_stall();
      test_map();
      test_irq();
      test_reset_mid_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mmio_bus_controller.md
Name: mmio_bus_controller

Overview:
Parametrised memory-map controller between the single-cycle RISC-V core's data port and the data RAM, GPIO channels and UART.
- Decodes the configurable MMIO window and routes writes and read data.
- Adds an RX byte FIFO, sticky error flags and a TX-send handshake that stalls the core while the transmitter is busy.
- Flags unmapped accesses.

Parameters:
- DATA_WIDTH, 32, bus data width
- ADDR_WIDTH, 32, bus address width
- RAM_BASE, 32'h10010000, first data-RAM byte address
- MMIO_BASE, 32'h10010024, first MMIO address; RAM occupies [RAM_BASE, MMIO_BASE)
- GPIO_CH, 2, number of GPIO channels (1..8)
- RX_DEPTH, 4, RX FIFO depth in bytes (power of 2, >=2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- re  in  1  core read strobe
- we  in  1  core write strobe
- A  in  ADDR_WIDTH  byte address
- WD  in  DATA_WIDTH  write data
- RD  out  DATA_WIDTH  read data, combinational
- stall  out  1  hold core PC/strobes
- bus_err  out  1  unmapped access this cycle
- ReadRAM  in  DATA_WIDTH  RAM read data
- weRAM  out  1  RAM write enable
- AddrRAM  out  ADDR_WIDTH  RAM address (=A)
- DataRAM  out  DATA_WIDTH  RAM write data (=WD)
- gpio_we  out  GPIO_CH  per-channel write enable
- gpio_wdata  out  DATA_WIDTH  GPIO write data (=WD)
- gpio_rdata  in  GPIO_CH*DATA_WIDTH  flattened channel inputs; ch i at [i*DATA_WIDTH +: DATA_WIDTH]
- rx_valid  in  1  one-cycle pulse: byte received
- rx_byte  in  8  received byte
- parity_error  in  1  pulse: RX parity fault
- tx_busy  in  1  transmitter busy
- tx_data  out  8  registered TX byte
- tx_start  out  1  one-cycle TX start pulse
- irq  out  1  interrupt request

Behaviour:
- Map, word offsets from MMIO_BASE:
  - GPIO ch i: write +8i, read +8i+4
  - UART base U = MMIO_BASE + 8*GPIO_CH: RX_DATA U+0 (R, pops), TX_DATA U+4 (W), STATUS U+8 (R; W1C bits 2,3), TX_SEND U+C (W nonzero = send; R = tx_busy), IRQ_EN U+10 (R/W bit0)
- RAM hit: RAM_BASE <= A < MMIO_BASE. weRAM = hit & we & ~stall; RD = ReadRAM when re.
- Any re/we outside RAM and the map: bus_err=1, no side effects, RD=0. RD=0 whenever re=0.
- STATUS bits:
  - [0] rx_not_empty
  - [1] tx_busy
  - [2] rx_overflow, sticky
  - [3] parity_err, sticky
  - [7:4] FIFO count; remaining bits 0
- RX FIFO:
  - rx_valid pushes rx_byte.
  - RX_DATA read returns head zero-extended and pops at the clock edge.
  - Read while empty returns 0, no pop.
  - Push while full: byte dropped, rx_overflow set.
  - Simultaneous push and pop while full: both happen, no overflow.
  - Pointers wrap modulo RX_DEPTH.
- Sticky flags: set by event; cleared by a STATUS write with 1 in the bit; set wins over a same-cycle clear.
- TX_DATA write: tx_data <= WD[7:0] on the next edge.
- TX FSM:
  - IDLE: TX_SEND write with WD!=0 → SEND if tx_busy=0, else WAIT with stall=1.
  - WAIT: stall=1 until tx_busy=0 → SEND.
  - SEND: tx_start=1 for one cycle, stall=0 → IDLE. The core's write completes in the SEND cycle and is not re-accepted.
  - TX_SEND write with WD=0: no action.
- While stall=1, no other side effects are taken (no pops, RAM/GPIO writes, or register writes).
- Reset, async on rst_n=0: FSM IDLE; FIFO empty; flags 0; tx_data=0; tx_start=0; stall=0; IRQ_EN=0; irq=0. Reset during WAIT drops the pending send.

Optional Feature:
- Macro MMIO_IRQ_EN.
- Defined: irq is registered, = IRQ_EN[0] & (rx_not_empty | rx_overflow | parity_err); it updates one cycle after its cause.
- Undefined: irq tied 0; IRQ_EN reads 0 and writes are ignored, with no bus_err.

Test Plan (defaults: GPIO_CH=2, U=0x10010034):
- Write 0xA5A5 to 0x10010024, then 0x1 to 0x1001002C → gpio_we=2'b01 then 2'b10. Read 0x10010030 with ch1 input 0x5A → RD=0x5A.
- Push 0x11,0x22,0x33,0x44,0x55 → STATUS=0x45 (count 4, overflow). Reads of 0x10010034 return 0x11..0x44; fifth read returns 0. Write 0x4 to STATUS → bit2 clears.
- Write 0x41 to TX_DATA, then 1 to TX_SEND with tx_busy=0 → tx_data=0x41, single tx_start pulse, stall never set.
- With tx_busy=1 for 5 cycles, write 1 to TX_SEND → stall high 5 cycles, then tx_start pulse; RAM write attempted during stall is not applied.
- Read 0x10020000 → bus_err=1, RD=0. Read 0x10010000 with ReadRAM=0xDEADBEEF → RD=0xDEADBEEF.
- MMIO_IRQ_EN: write IRQ_EN=1, pulse parity_error → irq=1 next cycle; write 0x8 to STATUS → irq=0 next cycle. Assert rst_n=0 mid-WAIT → stall=0, irq=0 immediately.
